// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for a Y86-64 SEQ datapath. Owns the architectural PC,
// the processor status and a retired-instruction counter, and steps each
// instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, one stage enable
// per cycle. The control inputs (start, fetch results, cnd, dmem_error) are
// sampled on the rising edge that ends the corresponding state; there is no
// valid/ready handshake. state_o exposes the FSM state for observation.
module seq_stage_controller #(
  parameter logic [63:0] MAX_PC       = 64'd1023,
  parameter bit          SKIP_INVALID = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] start_pc_i,
  input  logic [3:0]  icode_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        cnd_i,
  input  logic        dmem_error_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valP_i,
  input  logic [63:0] valM_i,
  output logic [63:0] PC_o,
  output logic        fetch_en_o,
  output logic        decode_en_o,
  output logic        exec_en_o,
  output logic        cc_update_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        busy_o,
  output logic [2:0]  stat_o,
  output logic [31:0] instr_count_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED, S_ERROR
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] count_q, count_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;

  logic        mem_use, wb_use;
  logic [63:0] next_pc;
  logic [31:0] count_inc;

  // Which instructions touch data memory / the register file (registered icode).
  always_comb begin
    mem_use = 1'b0;
    wb_use  = 1'b0;
    case (icode_q)
      4'h2, 4'h3, 4'h6:       wb_use  = 1'b1;
      4'h4:                   mem_use = 1'b1;
      4'h5, 4'h8, 4'h9,
      4'hA, 4'hB: begin
        mem_use = 1'b1;
        wb_use  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-PC selection and saturating retire increment.
  always_comb begin
    next_pc = valP_i;
    case (icode_q)
      4'h8:    next_pc = valC_i;
      4'h7:    next_pc = cnd_q ? valC_i : valP_i;
      4'h9:    next_pc = valM_i;
      default: next_pc = valP_i;
    endcase
    count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
  end

  // Sequencer next-state: PC, status, counter and latched icode/cnd.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    count_d = count_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start_i) begin
          pc_d    = start_pc_i;
          count_d = 32'd0;
          if (start_pc_i > MAX_PC) begin
            stat_d  = STAT_ADR;
            state_d = S_ERROR;
          end else begin
            stat_d  = STAT_AOK;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        icode_d = icode_i;
        if (imem_error_i) begin
          stat_d  = STAT_ADR;
          state_d = S_ERROR;
        end else if (!instr_valid_i) begin
          if (SKIP_INVALID) begin
            pc_d = pc_q + 64'd1;
          end else begin
            stat_d  = STAT_INS;
            state_d = S_ERROR;
          end
        end else if (icode_i == 4'h0) begin
          stat_d  = STAT_HLT;
          count_d = count_inc;
          state_d = S_HALTED;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        cnd_d   = cnd_i;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (dmem_error_i && mem_use) begin
          stat_d  = STAT_ADR;
          state_d = S_ERROR;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        count_d = count_inc;
        if (next_pc > MAX_PC) begin
          stat_d  = STAT_ADR;
          state_d = S_ERROR;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= 64'd0;
      stat_q  <= STAT_AOK;
      count_q <= 32'd0;
      icode_q <= 4'h0;
      cnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      count_q <= count_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
    end
  end

  // Stage enables decoded purely from registered state and icode.
  always_comb begin
    fetch_en_o    = (state_q == S_FETCH);
    decode_en_o   = (state_q == S_DECODE);
    exec_en_o     = (state_q == S_EXECUTE);
    cc_update_o   = (state_q == S_EXECUTE) && (icode_q == 4'h6);
    mem_en_o      = (state_q == S_MEMORY) && mem_use;
    wb_en_o       = (state_q == S_WRITEBACK) && wb_use;
    busy_o        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                    (state_q == S_MEMORY) || (state_q == S_WRITEBACK);
    PC_o          = pc_q;
    stat_o        = stat_q;
    instr_count_o = count_q;
    state_o       = state_q;
  end

endmodule
